// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt front end: FSM state encoding and
// the ceiling-log2 helper used to size the encoded interrupt id.
package irq_controller_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      SERVICE = 2'd2
   } state_t;

   // Number of bits needed to represent 'value' (clogb2(15) = 4).
   function automatic int clogb2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((value >> i) != 0) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/irq_controller_priority_encoder.sv
// Combinational priority encoder: B is the index of the highest set bit
// of A, ANY flags that at least one bit is set. B is 0 when A is 0.
module priority_encoder #(
   parameter int WIDTH    = 16,
   parameter int ID_WIDTH = 4
) (
   input  logic [WIDTH-1:0]    A,
   output logic [ID_WIDTH-1:0] B,
   output logic                ANY
);

   // Scan upward so that the last (highest) set index overrides lower ones.
   always_comb begin
      B   = '0;
      ANY = |A;
      for (int i = 0; i < WIDTH; i++) begin
         if (A[i]) begin
            B = ID_WIDTH'(i);
         end
      end
   end

endmodule

// File: rtl/irq_controller.sv
// Interrupt front end: synchronises raw lines, latches edge requests into
// a pending register, masks and priority-encodes them, and presents one
// winner at a time to the CPU with a valid/ready handshake until EOI.
module irq_controller
   import irq_controller_pkg::*;
#(
   parameter int                   IRQ_WIDTH  = 16,
   parameter int                   ID_WIDTH   = clogb2(IRQ_WIDTH - 1),
   parameter logic [IRQ_WIDTH-1:0] EDGE_LINES = {IRQ_WIDTH{1'b1}}
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IRQ_WIDTH-1:0] irq_in,
   input  logic                 mask_we,
   input  logic [IRQ_WIDTH-1:0] mask_wdata,
   output logic [IRQ_WIDTH-1:0] mask_o,
   output logic [IRQ_WIDTH-1:0] pending_o,
   output logic                 req_valid,
   output logic [ID_WIDTH-1:0]  req_id,
   input  logic                 req_ready,
   output logic                 busy,
   input  logic                 eoi
);

   logic [IRQ_WIDTH-1:0] r_s1;
   logic [IRQ_WIDTH-1:0] r_s2;
   logic [IRQ_WIDTH-1:0] r_s2_d;
   logic [IRQ_WIDTH-1:0] r_pending;
   logic [IRQ_WIDTH-1:0] r_mask;
   logic [ID_WIDTH-1:0]  r_req_id;
   state_t               r_state;

   state_t               w_state_next;
   logic [IRQ_WIDTH-1:0] w_cand;
   logic [IRQ_WIDTH-1:0] w_clr;
   logic [IRQ_WIDTH-1:0] w_pending_next;
   logic [ID_WIDTH-1:0]  w_enc_id;
   logic                 w_any;
   logic                 w_capture;
   logic                 w_accept;

   // Two-flop synchroniser per line plus a delayed copy for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1   <= '0;
         r_s2   <= '0;
         r_s2_d <= '0;
      end else begin
         r_s1   <= irq_in;
         r_s2   <= r_s1;
         r_s2_d <= r_s2;
      end
   end

   // Mask register, writable in every FSM state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mask <= '0;
      end else if (mask_we) begin
         r_mask <= mask_wdata;
      end
   end

   // Per-line pending update. Edge lines: a fresh rising edge wins over a
   // same-cycle clear so no request is lost. Level lines follow s2 and are
   // never cleared by the handshake.
   genvar gi;
   generate
      for (gi = 0; gi < IRQ_WIDTH; gi++) begin : g_line
         assign w_clr[gi] = w_accept && (r_req_id == ID_WIDTH'(gi));
         assign w_pending_next[gi] = EDGE_LINES[gi]
            ? ((r_pending[gi] & ~w_clr[gi]) | (r_s2[gi] & ~r_s2_d[gi]))
            : r_s2[gi];
      end
   endgenerate

   // Pending register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pending <= '0;
      end else begin
         r_pending <= w_pending_next;
      end
   end

   // Mask gates presentation only; pending keeps latching underneath.
   assign w_cand = r_pending & r_mask;

   priority_encoder #(
      .WIDTH    (IRQ_WIDTH),
      .ID_WIDTH (ID_WIDTH)
   ) u_prio (
      .A   (w_cand),
      .B   (w_enc_id),
      .ANY (w_any)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and outputs. The id is captured only when leaving IDLE, so
   // later requests or mask changes cannot disturb a presented interrupt.
   always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      w_accept     = 1'b0;
      req_valid    = 1'b0;
      busy         = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_capture    = 1'b1;
               w_state_next = PRESENT;
            end
         end
         PRESENT: begin
            req_valid = 1'b1;
            if (req_ready) begin
               w_accept     = 1'b1;
               w_state_next = SERVICE;
            end
         end
         SERVICE: begin
            busy = 1'b1;
            if (eoi) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Captured interrupt id, held through PRESENT and SERVICE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_req_id <= '0;
      end else if (w_capture) begin
         r_req_id <= w_enc_id;
      end
   end

   assign req_id    = r_req_id;
   assign pending_o = r_pending;
   assign mask_o    = r_mask;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios plus a randomized loop, with
// expected ids queued by the stimulus and compared by a handshake monitor.
module tb_irq_controller;

   localparam int          W    = 16;
   localparam logic [W-1:0] EDGE = 16'hFF7F;  // line 7 is level-sensitive

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] irq_in = '0;
   logic         mask_we = 1'b0;
   logic [W-1:0] mask_wdata = '0;
   logic [W-1:0] mask_o;
   logic [W-1:0] pending_o;
   logic         req_valid;
   logic [3:0]   req_id;
   logic         req_ready = 1'b0;
   logic         busy;
   logic         eoi = 1'b0;

   int           checks = 0;
   int           errors = 0;
   int           exp_q[$];
   logic [W-1:0] m_pend = '0;   // reference pending state
   logic [W-1:0] m_mask = '0;   // reference mask

   always #5 clk = ~clk;

   irq_controller #(
      .IRQ_WIDTH  (W),
      .EDGE_LINES (EDGE)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .irq_in     (irq_in),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .mask_o     (mask_o),
      .pending_o  (pending_o),
      .req_valid  (req_valid),
      .req_id     (req_id),
      .req_ready  (req_ready),
      .busy       (busy),
      .eoi        (eoi)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Highest set index computed arithmetically.
   function automatic int top_id(input logic [W-1:0] v);
      return $clog2(int'(v) + 1) - 1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_mask(input logic [W-1:0] m);
      mask_we    = 1'b1;
      mask_wdata = m;
      tick();
      mask_we = 1'b0;
      m_mask  = m;
      check("mask_readback", 32'(mask_o), 32'(m));
   endtask

   task automatic pulse_irq(input logic [W-1:0] bits);
      irq_in = bits;
      tick();
      irq_in = '0;
      m_pend = m_pend | (bits & EDGE);
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!req_valid && n < 40) begin
         tick();
         n++;
      end
      check(name, 32'(req_valid), 32'd1);
   endtask

   // Serve the current highest-priority candidate of the model.
   task automatic serve_one();
      int id;
      id = top_id(m_pend & m_mask);
      exp_q.push_back(id);
      wait_valid("serve_valid");
      repeat ($urandom_range(0, 2)) tick();
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      if (EDGE[id]) m_pend[id] = 1'b0;
      check("busy_after_ack", 32'(busy), 32'd1);
      check("pending_after_ack", 32'(pending_o), 32'(m_pend));
      repeat ($urandom_range(0, 2)) tick();
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      check("idle_after_eoi", 32'({busy, req_valid}), 32'd0);
   endtask

   task automatic drain();
      while ((m_pend & m_mask) != '0) serve_one();
   endtask

   // Monitor: every accepted handshake is compared with the queued id.
   always @(negedge clk) begin
      if (!rst && req_valid && req_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_handshake actual=%0d required=none", req_id);
         end else begin
            int e;
            e = exp_q.pop_front();
            $display("handshake id=%0d expected=%0d", req_id, e);
            check("handshake_id", 32'(req_id), 32'(e));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] p;
      // Reset state
      repeat (3) tick();
      check("rst_valid", 32'(req_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_pending", 32'(pending_o), 32'd0);
      check("rst_mask", 32'(mask_o), 32'd0);
      check("rst_id", 32'(req_id), 32'd0);
      rst = 1'b0;
      tick();

      // Edge line basic: exact 4-edge latency
      write_mask(16'hFFFF);
      irq_in[3] = 1'b1;
      tick();
      irq_in[3] = 1'b0;
      tick();
      tick();
      check("basic_pending_e3", 32'(pending_o), 32'h0008);
      check("basic_valid_e3", 32'(req_valid), 32'd0);
      tick();
      check("basic_valid_e4", 32'(req_valid), 32'd1);
      check("basic_id_e4", 32'(req_id), 32'd3);
      m_pend[3] = 1'b1;
      serve_one();

      // Priority: 9 before 2, 2 re-presented one edge after eoi
      pulse_irq(16'h0204);
      repeat (4) tick();
      serve_one();
      tick();
      check("repres_valid", 32'(req_valid), 32'd1);
      check("repres_id", 32'(req_id), 32'd2);
      serve_one();

      // Mask gates presentation but not latching
      write_mask(16'h0000);
      pulse_irq(16'h0020);
      repeat (5) tick();
      check("masked_pending", 32'(pending_o), 32'h0020);
      check("masked_valid", 32'(req_valid), 32'd0);
      mask_we = 1'b1;
      mask_wdata = 16'h0020;
      tick();
      mask_we = 1'b0;
      m_mask = 16'h0020;
      check("unmask_valid_e1", 32'(req_valid), 32'd0);
      tick();
      check("unmask_valid_e2", 32'(req_valid), 32'd1);
      check("unmask_id", 32'(req_id), 32'd5);
      serve_one();

      // Level line 7 held through eoi is re-presented
      write_mask(16'h0080);
      irq_in[7] = 1'b1;
      repeat (5) tick();
      m_pend[7] = 1'b1;
      serve_one();
      exp_q.push_back(7);
      wait_valid("level_repres");
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      irq_in[7] = 1'b0;
      repeat (5) tick();
      m_pend[7] = 1'b0;
      check("level_dropped", 32'(pending_o), 32'(m_pend));
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      repeat (3) tick();
      check("level_no_repres", 32'(req_valid), 32'd0);

      // Race: new edge on line 4 on the handshake cycle survives
      write_mask(16'h0010);
      pulse_irq(16'h0010);
      repeat (4) tick();
      exp_q.push_back(4);
      check("race_valid", 32'(req_valid), 32'd1);
      irq_in[4] = 1'b1;
      tick();
      irq_in[4] = 1'b0;
      tick();
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      check("race_busy", 32'(busy), 32'd1);
      check("race_pending", 32'(pending_o), 32'h0010);
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      serve_one();

      // Stability of a presented request
      write_mask(16'h0002);
      pulse_irq(16'h0002);
      repeat (4) tick();
      exp_q.push_back(1);
      pulse_irq(16'h8000);
      write_mask(16'h0000);
      for (int i = 0; i < 6; i++) begin
         check("stable_valid", 32'(req_valid), 32'd1);
         check("stable_id", 32'(req_id), 32'd1);
         tick();
      end
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      m_pend[1] = 1'b0;
      check("stable_busy", 32'(busy), 32'd1);
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      repeat (3) tick();
      check("stable_masked_idle", 32'(req_valid), 32'd0);

      // Reset mid-cycle in SERVICE
      write_mask(16'hFFFF);
      exp_q.push_back(15);
      wait_valid("rst_pre_valid");
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      m_pend[15] = 1'b0;
      pulse_irq(16'h0100);
      repeat (4) tick();
      check("rst_pre_busy", 32'(busy), 32'd1);
      check("rst_pre_pending", 32'(pending_o), 32'h0100);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("rst_async_busy", 32'(busy), 32'd0);
      check("rst_async_valid", 32'(req_valid), 32'd0);
      check("rst_async_id", 32'(req_id), 32'd0);
      check("rst_async_pending", 32'(pending_o), 32'd0);
      check("rst_async_mask", 32'(mask_o), 32'd0);
      tick();
      rst = 1'b0;
      m_pend = '0;
      m_mask = '0;
      write_mask(16'hFFFF);
      repeat (8) tick();
      check("post_rst_valid", 32'(req_valid), 32'd0);
      check("post_rst_pending", 32'(pending_o), 32'd0);

      // Randomized traffic against the reference model
      for (int it = 0; it < 40; it++) begin
         write_mask(W'($urandom));
         repeat (2) tick();
         drain();
         eoi = 1'b1;          // ignored in IDLE
         tick();
         eoi = 1'b0;
         req_ready = 1'b1;    // ignored outside PRESENT
         tick();
         req_ready = 1'b0;
         p = W'($urandom) & EDGE;
         pulse_irq(p);
         repeat (5) tick();
         check("rand_pending", 32'(pending_o), 32'(m_pend));
         drain();
         repeat (2) tick();
         check("rand_idle", 32'(req_valid), 32'd0);
      end

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt front end for the YAMIPS core. It synchronises raw interrupt lines and latches edge-type requests into a pending register. Pending lines are masked and passed through the `priority_encoder` stage to pick the highest-index winner. That winner is presented to the CPU exception logic with a valid/ready handshake, and one interrupt is held in service until end-of-interrupt.

## Interface
- `IRQ_WIDTH`, 16: number of interrupt lines.
- `ID_WIDTH`, clogb2(IRQ_WIDTH-1) = 4: width of the encoded interrupt id.
- `EDGE_LINES`, {IRQ_WIDTH{1'b1}}: per-line mode. 1 = rising-edge latched, 0 = level.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset. Asynchronous and active-high: assertion clears all state immediately.
- `irq_in`  in  IRQ_WIDTH  raw interrupt lines, asynchronous to `clk`.
- `mask_we`  in  1  write strobe for the mask register.
- `mask_wdata`  in  IRQ_WIDTH  new mask. 1 = line enabled.
- `mask_o`  out  IRQ_WIDTH  current mask. Reset value 0, so all lines are disabled.
- `pending_o`  out  IRQ_WIDTH  pending register, for status reads. Reset value 0.
- `req_valid`  out  1  interrupt request to the CPU. Reset value 0.
- `req_id`  out  ID_WIDTH  id of the presented interrupt. Reset value 0.
- `req_ready`  in  1  CPU accepts the request.
- `busy`  out  1  an interrupt is in service. Reset value 0.
- `eoi`  in  1  single-cycle end-of-interrupt pulse from the CPU.

## Operation
- **Synchroniser:** two flops per line, `s1` then `s2`. A third flop, `s2_d`, supports edge detection. All reset to 0.
- **Pending, edge line:** `pending[i] <= (pending[i] & ~clr[i]) | (s2[i] & ~s2_d[i])`.
  - `clr[i]` is high on the handshake cycle for line i.
  - When a set and a clear hit the same bit in the same cycle, the set wins and no edge is lost.
- **Pending, level line:** `pending[i] <= s2[i]` every cycle. The handshake does not clear it.
- **Masking:** the mask gates presentation only. Edge requests keep latching while a line is masked.
- **Mask write:** `mask_we` takes effect on the next edge and is valid in every FSM state.
- **Candidate selection:** `cand = pending & mask` feeds `priority_encoder`. The highest set index wins. `ANY` means a candidate exists.
- **FSM `IDLE`:**
  - `req_valid` = 0, `busy` = 0.
  - If `ANY`, register the encoder output into `req_id` and go to `PRESENT`.
- **FSM `PRESENT`:**
  - `req_valid` = 1 and `req_id` is frozen.
  - Neither a later higher-priority request nor masking or deasserting the captured line withdraws or changes the request.
  - On `req_ready` = 1: assert `clr` for `req_id` (edge lines only) and go to `SERVICE`.
- **FSM `SERVICE`:**
  - `busy` = 1, `req_valid` = 0, `req_id` holds its value.
  - On `eoi`, go to `IDLE`.
- **Ignored inputs:** `eoi` in `IDLE` or `PRESENT` and `req_ready` outside `PRESENT` have no effect.
- **Nesting:** none. One interrupt is in flight at a time.
- **Illegal states:** an unused state encoding returns to `IDLE`.

## Timing
- **Edge or level rise to request:** for `irq_in` rising before clk edge 1 (setup met):
  - `s2` = 1 after edge 2.
  - `pending` = 1 after edge 3.
  - `req_valid` = 1 after edge 4, provided the FSM is in `IDLE` and the line is unmasked.
- **Re-present after `eoi`:** if `eoi` is sampled at edge n, the FSM is in `IDLE` after n. With a candidate still pending, `req_valid` is high again after n+1.
- **Handshake:** `req_valid && req_ready` sampled at edge m means `busy` = 1 and the edge pending bit = 0 after m.
- **Reset mid-operation:** asserting `rst` in any state clears FSM, pending, mask, synchronisers and all outputs without waiting for a clock edge. Interrupts in flight are dropped.
- **Encoder path:** fully combinational from `pending`/`mask` to `req_id` capture. It must close timing at core frequency for `IRQ_WIDTH` ≤ 32.

## Structure
- **Shared package:** FSM state encoding (`IDLE`, `PRESENT`, `SERVICE`, 2 bits) and the `clogb2` function in the shared CPU defines package.
- **Sub-module:** instantiate `priority_encoder` once, with A = `cand`, B to the `req_id` capture, and ANY to the FSM. Its `one_hot_decoder` is reused unchanged.

## Test plan
- **Edge line, basic:** mask = 0xFFFF, pulse `irq_in[3]` for 1 cycle. Expect `req_valid` after edge 4 with `req_id` = 3. Assert `req_ready`, expect `busy` = 1 and `pending_o` = 0. Pulse `eoi`, expect `IDLE`.
- **Priority:** `irq_in[2]` and `irq_in[9]` rise together. Expect `req_id` = 9. After `eoi`, expect `req_id` = 2 one cycle later.
- **Mask:** mask = 0, pulse `irq_in[5]`. Expect `pending_o[5]` = 1 and `req_valid` = 0. Write mask = 0x0020, expect `req_valid` two edges later with `req_id` = 5.
- **Level and race:** level line 7 held high through `eoi`, expect it re-presented. On edge line 4, a new rising edge on the handshake cycle leaves `pending_o[4]` = 1.
- **Stability:** in `PRESENT` with `req_id` = 1, raise line 15 and clear the mask. Expect `req_valid` = 1 and `req_id` = 1 unchanged until `req_ready`.
- **Reset:** assert `rst` in `SERVICE` mid-cycle. Expect all outputs and `pending_o` = 0 before the next edge, and no request after release until a new edge.
